rv_instr_encoder: RTL and testbench

- Inverse of the immediate generator: packs RV32I fields (type, opcode, funct3/7, registers, 32-bit immediate) into a 32-bit instruction word.
- Range- and alignment-checks the immediate and scatters its bits into the ISA-defined positions.
- Writes each valid word into instruction memory at an auto-incrementing byte address.
- Used by the program-load path and test infrastructure to fill imem before the single-cycle core runs.

---
 rtl/rv_instr_encoder.sv | 210 +++++++++++++++++++++
 tb/tb_rv_instr_encoder.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder
// Packs RV32I instruction fields into a 32-bit word and streams each legal word
// into instruction memory at an auto-incrementing byte address. Out-of-range or
// misaligned immediates and illegal types are rejected with a one-cycle error
// pulse instead of a write. Each load session is opened by start and closes
// once DEPTH words have been committed.

module rv_instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            start_addr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_type,
    input  logic [6:0]                   in_opcode,
    input  logic [2:0]                   in_funct3,
    input  logic [6:0]                   in_funct7,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [31:0]                  in_imm,
    output logic                         imem_we,
    output logic [ADDR_W-1:0]            imem_addr,
    output logic [31:0]                  imem_wdata,
    input  logic                         imem_ready,
    output logic                         err_valid,
    output logic [1:0]                   err_code,
    output logic [$clog2(DEPTH+1)-1:0]   word_count,
    output logic                         done
);

    localparam int CNT_W = $clog2(DEPTH+1);

    // Instruction format selectors carried on in_type
    localparam logic [2:0] T_R = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;

    // Rejection reasons reported on err_code
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_TYPE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]  code;
        logic [31:0] word;
    } enc_t;

    // Encode one field bundle. The word is built even when the bundle is
    // rejected; the caller discards it whenever code is non-zero. Alignment is
    // checked after range so that a misaligned immediate reports ERR_ALIGN even
    // when it is also out of range.
    function automatic enc_t encode(
        input logic [2:0]  ty,
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        enc_t r;
        logic fits12;
        logic fits13;
        logic fits21;
        r.code = ERR_NONE;
        r.word = 32'd0;
        // A value fits an N-bit signed field when every bit above N-2 equals bit N-1
        fits12 = (imm[31:11] == {21{imm[11]}});
        fits13 = (imm[31:12] == {20{imm[12]}});
        fits21 = (imm[31:20] == {12{imm[20]}});
        case (ty)
            T_R: begin
                r.word = {f7, rs2, rs1, f3, rd, op};
            end
            T_I: begin
                if (!fits12) r.code = ERR_RANGE;
                r.word = {imm[11:0], rs1, f3, rd, op};
            end
            T_S: begin
                if (!fits12) r.code = ERR_RANGE;
                r.word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            T_B: begin
                if (!fits13) r.code = ERR_RANGE;
                if (imm[0])  r.code = ERR_ALIGN;
                r.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            end
            T_U: begin
                if (imm[11:0] != 12'd0) r.code = ERR_ALIGN;
                r.word = {imm[31:12], rd, op};
            end
            T_J: begin
                if (!fits21) r.code = ERR_RANGE;
                if (imm[0])  r.code = ERR_ALIGN;
                r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            default: begin
                r.code = ERR_TYPE;
            end
        endcase
        return r;
    endfunction

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_err_valid;
    logic [1:0]          r_err_code;
    logic [CNT_W-1:0]    r_count;
    logic                r_done;

    logic                w_commit;
    logic                w_accept;
    logic                w_full;
    logic [CNT_W:0]      w_pending_total;
    logic [CNT_W-1:0]    w_count_next;
    logic [ADDR_W-1:0]   w_start_base;
    enc_t                w_enc;
    logic                w_unused_addr_lsb;

    // Byte address bits [1:0] of start_addr are forced to zero
    assign w_start_base      = {start_addr[ADDR_W-1:2], 2'b00};
    assign w_unused_addr_lsb = ^start_addr[1:0];

    // Committed words plus the one still waiting for memory; once this reaches
    // DEPTH no further bundle may be taken, since it could never be written.
    assign w_pending_total = {1'b0, r_count} + {{CNT_W{1'b0}}, r_we};
    assign w_full          = (w_pending_total == (CNT_W+1)'(DEPTH));
    assign w_count_next    = r_count + CNT_W'(1);

    assign w_commit = r_we && imem_ready;
    assign in_ready = (r_state == S_RUN) && (!r_we || imem_ready) && !w_full;
    assign w_accept = in_valid && in_ready;

    assign w_enc = encode(in_type, in_opcode, in_funct3, in_funct7,
                          in_rd, in_rs1, in_rs2, in_imm);

    // Session FSM: write hold/commit, address and count tracking, error pulse.
    // r_addr always names the pending write, or the next write when none is
    // pending, so a commit and a new accept in one cycle place the new word at
    // the incremented address without extra bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_count     <= '0;
            r_done      <= 1'b0;
        end else if (start) begin
            // A new session discards any write still waiting on memory
            r_state     <= S_RUN;
            r_we        <= 1'b0;
            r_addr      <= w_start_base;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_count     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            if (w_commit) begin
                r_we    <= 1'b0;
                r_addr  <= r_addr + ADDR_W'(4);
                r_count <= w_count_next;
                if (w_count_next == CNT_W'(DEPTH)) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
            end
            if (w_accept) begin
                if (w_enc.code != ERR_NONE) begin
                    r_err_valid <= 1'b1;
                    r_err_code  <= w_enc.code;
                end else begin
                    r_we    <= 1'b1;
                    r_wdata <= w_enc.word;
                end
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign word_count = r_count;
    assign done       = r_done;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed vector table, hand-written hold/restart/
// reset sequences, then randomized traffic against a transaction-level model.

module tb_rv_instr_encoder;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_type;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;
    logic              err_valid;
    logic [1:0]        err_code;
    logic [CNT_W-1:0]  word_count;
    logic              done;

    always #5 clk = ~clk;

    rv_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_opcode  (in_opcode),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .word_count (word_count),
        .done       (done)
    );

    typedef struct {
        logic [2:0]  ty;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        exp_we;
        logic [31:0] exp_word;
        logic [1:0]  exp_code;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    vec_t vt[9];
    logic [31:0] bnd[12];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_type   = v.ty;
        in_opcode = v.op;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
        in_valid  = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),   64'd0);
        check({tag, "_imem_we"},    64'(imem_we),    64'd0);
        check({tag, "_imem_addr"},  64'(imem_addr),  64'd0);
        check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        check({tag, "_err_valid"},  64'(err_valid),  64'd0);
        check({tag, "_err_code"},   64'(err_code),   64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'd0);
        check({tag, "_done"},       64'(done),       64'd0);
    endtask

    // Reference encoder: signed range tests on the integer value and field
    // placement by shift-and-mask arithmetic.
    task automatic m_encode(input logic [2:0] ty, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm,
                            output logic [1:0] code, output logic [31:0] word);
        int v;
        logic [31:0] base_rs;
        v = imm;
        code = 2'd0;
        word = 32'd0;
        base_rs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (ty)
            3'd0: word = (32'(f7) << 25) | (32'(rs2) << 20) | base_rs | (32'(rd) << 7);
            3'd1: begin
                if (v < -2048 || v > 2047) code = 2'd1;
                word = ((imm & 32'hFFF) << 20) | base_rs | (32'(rd) << 7);
            end
            3'd2: begin
                if (v < -2048 || v > 2047) code = 2'd1;
                word = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base_rs
                     | ((imm & 32'h1F) << 7);
            end
            3'd3: begin
                if ((imm & 32'd1) != 0) code = 2'd2;
                else if (v < -4096 || v > 4094) code = 2'd1;
                word = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                     | (32'(rs2) << 20) | base_rs | (((imm >> 1) & 32'hF) << 8)
                     | (((imm >> 11) & 32'h1) << 7);
            end
            3'd4: begin
                if ((imm & 32'hFFF) != 0) code = 2'd2;
                word = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            end
            3'd5: begin
                if ((imm & 32'd1) != 0) code = 2'd2;
                else if (v < -1048576 || v > 1048574) code = 2'd1;
                word = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                     | (32'(rd) << 7) | 32'(op);
            end
            default: code = 2'd3;
        endcase
    endtask

    initial begin
        wr_t         mq[$];
        int          m_count;
        bit          m_active;
        logic [31:0] m_next;
        bit          m_err_pend;
        logic [1:0]  m_err_code;
        logic [1:0]  e_code;
        logic [31:0] e_word;
        bit          exp_ready;
        int          exp_cnt;
        logic [31:0] exp_addr;

        vt[0] = '{3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093, 2'd0};
        vt[1] = '{3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h00000008, 1'b1, 32'h00208463, 2'd0};
        vt[2] = '{3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 32'hFFDFF0EF, 2'd0};
        vt[3] = '{3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 1'b0, 32'h00000000, 2'd2};
        vt[4] = '{3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h00000007, 1'b0, 32'h00000000, 2'd2};
        vt[5] = '{3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b0, 32'h00000000, 2'd1};
        vt[6] = '{3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00100000, 1'b0, 32'h00000000, 2'd1};
        vt[7] = '{3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000000, 1'b0, 32'h00000000, 2'd3};
        vt[8] = '{3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hABCDE000, 1'b1, 32'hABCDE2B7, 2'd0};

        bnd = '{32'h000007FF, 32'hFFFFF800, 32'h00000800, 32'hFFFFF7FF,
                32'h00000FFE, 32'h00001000, 32'hFFFFF000, 32'hFFFFEFFE,
                32'h000FFFFE, 32'h00100000, 32'hFFF00000, 32'hFFEFFFFE};

        rst = 1'b1; start = 1'b0; start_addr = '0; in_valid = 1'b0; imem_ready = 1'b1;
        in_type = 3'd0; in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Bundle offered while idle must not be taken
        drive(vt[0]);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        check("idle_no_write", 64'(imem_we), 64'd0);

        // Directed table: one session from address 0
        start = 1'b1; start_addr = 32'h0;
        tick();
        start = 1'b0;
        exp_cnt = 0; exp_addr = 32'h0;
        for (int i = 0; i < 9; i++) begin
            drive(vt[i]);
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_we", i),        64'(imem_we),   64'(vt[i].exp_we));
            check($sformatf("vec%0d_err_valid", i), 64'(err_valid), 64'(!vt[i].exp_we));
            check($sformatf("vec%0d_err_code", i),  64'(err_code),  64'(vt[i].exp_code));
            check($sformatf("vec%0d_addr", i),      64'(imem_addr), 64'(exp_addr));
            if (vt[i].exp_we) begin
                check($sformatf("vec%0d_wdata", i), 64'(imem_wdata), 64'(vt[i].exp_word));
                exp_cnt++;
                exp_addr += 32'd4;
            end
            tick();
            check($sformatf("vec%0d_count", i), 64'(word_count), 64'(exp_cnt));
            check($sformatf("vec%0d_err_clear", i), 64'(err_valid), 64'd0);
        end
        check("full_done", 64'(done), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(vt[0]);
        tick();
        in_valid = 1'b0;
        check("done_ignored_we", 64'(imem_we), 64'd0);
        check("done_ignored_err", 64'(err_valid), 64'd0);
        check("done_count_held", 64'(word_count), 64'(DEPTH));

        // Held write under memory back-pressure, then commit + accept together
        start = 1'b1; start_addr = 32'h100;
        tick();
        start = 1'b0;
        imem_ready = 1'b0;
        drive(vt[0]);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(vt[1]);
            #1;
            check($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'd0);
            check($sformatf("hold%0d_we", k),       64'(imem_we),  64'd1);
            check($sformatf("hold%0d_addr", k),     64'(imem_addr), 64'h100);
            check($sformatf("hold%0d_wdata", k),    64'(imem_wdata), 64'hFFF00093);
            check($sformatf("hold%0d_count", k),    64'(word_count), 64'd0);
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_we", 64'(imem_we), 64'd1);
        check("b2b_addr", 64'(imem_addr), 64'h104);
        check("b2b_wdata", 64'(imem_wdata), 64'h00208463);
        check("b2b_count", 64'(word_count), 64'd1);
        tick();
        check("b2b_count2", 64'(word_count), 64'd2);
        check("b2b_we_clear", 64'(imem_we), 64'd0);

        // Restart while a write is pending drops it
        imem_ready = 1'b0;
        drive(vt[2]);
        tick();
        in_valid = 1'b0;
        check("pre_restart_we", 64'(imem_we), 64'd1);
        start = 1'b1; start_addr = 32'h303;
        tick();
        start = 1'b0;
        check("restart_we", 64'(imem_we), 64'd0);
        check("restart_count", 64'(word_count), 64'd0);
        check("restart_addr", 64'(imem_addr), 64'h300);
        check("restart_done", 64'(done), 64'd0);
        imem_ready = 1'b1;
        tick();
        check("restart_no_ghost", 64'(imem_we), 64'd0);
        drive(vt[8]);
        tick();
        in_valid = 1'b0;
        check("restart_new_addr", 64'(imem_addr), 64'h300);
        check("restart_new_wdata", 64'(imem_wdata), 64'hABCDE2B7);
        tick();

        // Reset in the middle of a session with a pending write
        imem_ready = 1'b0;
        drive(vt[0]);
        tick();
        in_valid = 1'b0;
        check("pre_rst_we", 64'(imem_we), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midrst");

        // Randomized traffic against the transaction-level model
        m_count = 0; m_active = 1'b0; m_next = 32'h0; m_err_pend = 1'b0; m_err_code = 2'd0;
        mq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start = (cyc == 0) || ($urandom_range(0, 99) < ((m_count == DEPTH) ? 30 : 2));
            if (start) begin
                start_addr = $urandom;
                in_valid   = 1'b0;
            end else begin
                in_valid = ($urandom_range(0, 99) < 70);
            end
            in_type   = 3'($urandom_range(0, 7));
            in_opcode = 7'($urandom);
            in_funct3 = 3'($urandom);
            in_funct7 = 7'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            case ($urandom_range(0, 4))
                0: in_imm = $urandom;
                1: in_imm = 32'($urandom_range(0, 8200)) - 32'd4100;
                2: in_imm = $urandom & 32'hFFFFF000;
                3: in_imm = (32'($urandom_range(0, 4194304)) - 32'd2097152) & ~32'd1;
                default: in_imm = bnd[$urandom_range(0, 11)];
            endcase
            imem_ready = ($urandom_range(0, 99) < 65);
            #1;
            check("rnd_count", 64'(word_count), 64'(m_count));
            check("rnd_done", 64'(done), 64'(m_count == DEPTH));
            check("rnd_err_valid", 64'(err_valid), 64'(m_err_pend));
            check("rnd_err_code", 64'(err_code), 64'(m_err_pend ? m_err_code : 2'd0));
            check("rnd_we", 64'(imem_we), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("rnd_addr", 64'(imem_addr), 64'(mq[0].addr));
                check("rnd_wdata", 64'(imem_wdata), 64'(mq[0].data));
            end
            exp_ready = m_active && ((m_count + mq.size()) < DEPTH) && (mq.size() == 0 || imem_ready);
            check("rnd_in_ready", 64'(in_ready), 64'(exp_ready));

            m_err_pend = 1'b0;
            if (start) begin
                mq.delete();
                m_count  = 0;
                m_next   = start_addr & ~32'd3;
                m_active = 1'b1;
            end else begin
                if (mq.size() != 0 && imem_ready) begin
                    void'(mq.pop_front());
                    m_count++;
                end
                if (in_valid && exp_ready) begin
                    m_encode(in_type, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
                             in_imm, e_code, e_word);
                    if (e_code != 2'd0) begin
                        m_err_pend = 1'b1;
                        m_err_code = e_code;
                    end else begin
                        mq.push_back('{addr: m_next, data: e_word});
                        m_next += 32'd4;
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
